// File: rtl/lsu_wr_queue_if.sv
// rtl/lsu_wr_queue_if.sv - LSU write-queue bus bundle: RMW/store intake, load probe, memory write port
interface lsu_wr_queue_if;
  logic [15:0] rmw_addr;
  logic [15:0] rmw_data;
  logic        rmw_data_rdy;
  logic        rmw_hold;
  logic        st_valid;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic [15:0] ld_addr;
  logic        ld_conflict;
  logic        q_empty;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_rdy;

  modport slave (
    input  rmw_addr, rmw_data, rmw_data_rdy, st_valid, st_addr, st_data, ld_addr, mem_rdy,
    output rmw_hold, st_ready, ld_conflict, q_empty, mem_wr, mem_addr, mem_data_out
  );

  modport master (
    output rmw_addr, rmw_data, rmw_data_rdy, st_valid, st_addr, st_data, ld_addr, mem_rdy,
    input  rmw_hold, st_ready, ld_conflict, q_empty, mem_wr, mem_addr, mem_data_out
  );
endinterface

// File: rtl/lsu_wr_queue.sv
// rtl/lsu_wr_queue.sv - in-order LSU write queue draining RMW results and stores to memory
module lsu_wr_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          a_rst_n,
  lsu_wr_queue_if.slave wq
);

  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [15:0]      addr_mem [DEPTH];
  logic [15:0]      data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  state_t           state_q, state_d;
  logic             mem_wr_q, mem_wr_d;
  logic [15:0]      mem_addr_q, mem_addr_d;
  logic [15:0]      mem_data_q, mem_data_d;

  logic             push_rmw, push_st, push, pop;
  logic [15:0]      push_addr, push_data;
  logic             conflict;
  logic [PTR_W-1:0] probe_idx;

  // RMW wins over stores; full is registered so rmw_hold never depends on rmw_data_rdy
  assign push_rmw  = wq.rmw_data_rdy & ~full_q;
  assign push_st   = wq.st_valid & ~full_q & ~wq.rmw_data_rdy;
  assign push      = push_rmw | push_st;
  assign push_addr = push_rmw ? wq.rmw_addr : wq.st_addr;
  assign push_data = push_rmw ? wq.rmw_data : wq.st_data;
  assign pop       = (state_q == S_WAIT) & wq.mem_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= push_addr;
      data_mem[wr_ptr_q] <= push_data;
    end
  end

  // The head stays queued while in flight, so it is still counted and still probed
  always_comb begin
    state_d    = state_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          mem_addr_d = addr_mem[rd_ptr_q];
          mem_data_d = data_mem[rd_ptr_q];
          mem_wr_d   = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wq.mem_rdy) begin
          mem_wr_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      state_q    <= S_IDLE;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      state_q    <= state_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Only entries already in the queue are probed; a same-cycle push is not visible yet
  always_comb begin
    conflict  = 1'b0;
    probe_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      probe_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[probe_idx] == wq.ld_addr)) conflict = 1'b1;
    end
  end

  assign wq.rmw_hold     = full_q;
  assign wq.st_ready     = ~full_q & ~wq.rmw_data_rdy;
  assign wq.ld_conflict  = conflict;
  assign wq.q_empty      = (count_q == '0) & (state_q == S_IDLE);
  assign wq.mem_wr       = mem_wr_q;
  assign wq.mem_addr     = mem_addr_q;
  assign wq.mem_data_out = mem_data_q;

endmodule

// File: tb/tb_lsu_wr_queue.sv
// tb/tb_lsu_wr_queue.sv - directed vector and sequence bench for lsu_wr_queue
module tb_lsu_wr_queue;

  logic clk = 1'b0;
  logic a_rst_n;
  always #5 clk = ~clk;

  lsu_wr_queue_if wq ();

  lsu_wr_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .wq      (wq)
  );

  typedef struct {
    logic        rmw_rdy;
    logic [15:0] rmw_addr;
    logic [15:0] rmw_data;
    logic        st_valid;
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic [15:0] ld_addr;
    logic        mem_rdy;
    logic        e_hold;
    logic        e_st_ready;
    logic        e_conf;
    logic        e_empty;
    logic        e_mem_wr;
    logic [15:0] e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl [17];
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];

  always @(negedge clk)
    if (a_rst_n && wq.mem_wr && wq.mem_rdy) got_q.push_back({wq.mem_addr, wq.mem_data_out});

  function automatic vec_t mk(input logic rr, input logic [15:0] ra, input logic [15:0] rd,
                              input logic sv, input logic [15:0] sa, input logic [15:0] sd,
                              input logic [15:0] la, input logic mr,
                              input logic eh, input logic es, input logic ec, input logic ee,
                              input logic ew, input logic [15:0] ea, input logic [15:0] ed);
    vec_t v;
    v.rmw_rdy = rr; v.rmw_addr = ra; v.rmw_data = rd;
    v.st_valid = sv; v.st_addr = sa; v.st_data = sd;
    v.ld_addr = la; v.mem_rdy = mr;
    v.e_hold = eh; v.e_st_ready = es; v.e_conf = ec; v.e_empty = ee;
    v.e_mem_wr = ew; v.e_addr = ea; v.e_data = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wq.rmw_data_rdy = 1'b0; wq.rmw_addr = '0; wq.rmw_data = '0;
    wq.st_valid = 1'b0; wq.st_addr = '0; wq.st_data = '0;
    wq.ld_addr = '0; wq.mem_rdy = 1'b0;
  endtask

  task automatic push_store(input logic [15:0] a, input logic [15:0] d, input bit rand_rdy);
    bit acc;
    acc = 1'b0;
    wq.st_addr = a; wq.st_data = d; wq.st_valid = 1'b1;
    for (int c = 0; c < 100 && !acc; c++) begin
      if (rand_rdy) wq.mem_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = wq.st_ready;
      tick();
    end
    wq.st_valid = 1'b0;
    wq.mem_rdy  = 1'b0;
    check($sformatf("store_accept_%h", a), 32'(acc), 32'd1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      wq.mem_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = wq.q_empty;
      tick();
    end
    wq.mem_rdy = 1'b0;
    check("drain_done", 32'(done), 32'd1);
  endtask

  task automatic compare_writes(input string name);
    check($sformatf("%s_count", name), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check($sformatf("%s[%0d]", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    tbl[0]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 16'h1234, 16'hBEEF, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 1, 0, 1, 16'h1234, 16'hBEEF);
    tbl[4]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 1, 0, 1, 16'h1234, 16'hBEEF);
    tbl[5]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1234, 1, 0, 1, 1, 0, 1, 16'h1234, 16'hBEEF);
    tbl[6]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000);
    tbl[7]  = mk(1, 16'h0040, 16'hA040, 1, 16'h0080, 16'hB080, 16'h0040, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    tbl[8]  = mk(0, 16'h0000, 16'h0000, 1, 16'h0080, 16'hB080, 16'h0040, 0, 0, 1, 1, 0, 0, 16'h0000, 16'h0000);
    tbl[9]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 1, 1, 0, 1, 16'h0040, 16'hA040);
    tbl[10] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h00C0, 0, 0, 1, 0, 0, 1, 16'h0040, 16'hA040);
    tbl[11] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0040, 1, 0, 1, 1, 0, 1, 16'h0040, 16'hA040);
    tbl[12] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0040, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
    tbl[13] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 1, 1, 0, 1, 16'h0080, 16'hB080);
    tbl[14] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0080, 1, 0, 1, 1, 0, 1, 16'h0080, 16'hB080);
    tbl[15] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0040, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000);
    tbl[16] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0080, 0, 0, 1, 0, 1, 0, 16'h0000, 16'h0000);

    a_rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_empty",  32'(wq.q_empty),     32'd1);
    check("rst_st_ready", 32'(wq.st_ready),    32'd1);
    check("rst_hold",     32'(wq.rmw_hold),    32'd0);
    check("rst_conflict", 32'(wq.ld_conflict), 32'd0);
    check("rst_mem_wr",   32'(wq.mem_wr),      32'd0);
    check("rst_mem_addr", 32'(wq.mem_addr),    32'd0);
    check("rst_mem_data", 32'(wq.mem_data_out), 32'd0);
    a_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 17; k++) begin
      wq.rmw_data_rdy = tbl[k].rmw_rdy; wq.rmw_addr = tbl[k].rmw_addr; wq.rmw_data = tbl[k].rmw_data;
      wq.st_valid = tbl[k].st_valid; wq.st_addr = tbl[k].st_addr; wq.st_data = tbl[k].st_data;
      wq.ld_addr = tbl[k].ld_addr; wq.mem_rdy = tbl[k].mem_rdy;
      @(negedge clk);
      check($sformatf("v%0d_hold", k),     32'(wq.rmw_hold),    32'(tbl[k].e_hold));
      check($sformatf("v%0d_st_ready", k), 32'(wq.st_ready),    32'(tbl[k].e_st_ready));
      check($sformatf("v%0d_conflict", k), 32'(wq.ld_conflict), 32'(tbl[k].e_conf));
      check($sformatf("v%0d_q_empty", k),  32'(wq.q_empty),     32'(tbl[k].e_empty));
      check($sformatf("v%0d_mem_wr", k),   32'(wq.mem_wr),      32'(tbl[k].e_mem_wr));
      if (tbl[k].e_mem_wr) begin
        check($sformatf("v%0d_mem_addr", k), 32'(wq.mem_addr),     32'(tbl[k].e_addr));
        check($sformatf("v%0d_mem_data", k), 32'(wq.mem_data_out), 32'(tbl[k].e_data));
      end
      tick();
    end
    idle_inputs();
    tick();
    exp_q.push_back({16'h1234, 16'hBEEF});
    exp_q.push_back({16'h0040, 16'hA040});
    exp_q.push_back({16'h0080, 16'hB080});
    compare_writes("vec_order");

    for (int i = 0; i < 4; i++) push_store(16'h0010 + 16'(i), 16'h5010 + 16'(i), 1'b0);
    @(negedge clk);
    check("full_st_ready", 32'(wq.st_ready), 32'd0);
    check("full_hold",     32'(wq.rmw_hold), 32'd1);
    check("full_mem_addr", 32'(wq.mem_addr), 32'h0010);
    tick();
    wq.rmw_data_rdy = 1'b1; wq.rmw_addr = 16'h0099; wq.rmw_data = 16'h7099;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("full_hold_%0d", i), 32'(wq.rmw_hold), 32'd1);
      tick();
    end
    wq.mem_rdy = 1'b1;
    @(negedge clk);
    check("full_hold_at_pop", 32'(wq.rmw_hold), 32'd1);
    tick();
    wq.mem_rdy = 1'b0;
    @(negedge clk);
    check("full_hold_after_pop", 32'(wq.rmw_hold), 32'd0);
    tick();
    wq.rmw_data_rdy = 1'b0;
    drain(200);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0010 + 16'(i), 16'h5010 + 16'(i)});
    exp_q.push_back({16'h0099, 16'h7099});
    compare_writes("full_order");

    for (int i = 0; i < 10; i++) begin
      push_store(16'h0200 + 16'(3 * i), 16'hC000 + 16'(i), 1'b1);
      exp_q.push_back({16'h0200 + 16'(3 * i), 16'hC000 + 16'(i)});
    end
    drain(400);
    compare_writes("wrap_order");

    for (int i = 0; i < 3; i++) push_store(16'h0301 + 16'(i), 16'hD000 + 16'(i), 1'b0);
    tick();
    wq.ld_addr = 16'h0301;
    @(negedge clk);
    check("pre_rst_mem_wr",   32'(wq.mem_wr),      32'd1);
    check("pre_rst_conflict", 32'(wq.ld_conflict), 32'd1);
    tick();
    #2;
    a_rst_n = 1'b0;
    #1;
    check("mid_rst_mem_wr",   32'(wq.mem_wr),      32'd0);
    check("mid_rst_q_empty",  32'(wq.q_empty),     32'd1);
    check("mid_rst_conflict", 32'(wq.ld_conflict), 32'd0);
    check("mid_rst_st_ready", 32'(wq.st_ready),    32'd1);
    check("mid_rst_mem_addr", 32'(wq.mem_addr),    32'd0);
    tick();
    a_rst_n = 1'b1;
    got_q.delete();
    tick();
    push_store(16'h0400, 16'h4444, 1'b0);
    drain(100);
    exp_q.push_back({16'h0400, 16'h4444});
    compare_writes("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
